wts_adsr_key_controller: RTL and testbench
==========================================

// Module: wts_adsr_key_controller
// PURPOSE
//   CPU-side front end for wts_adsr_envelope_generator_5ch. Decodes byte writes into per-channel
//   AR/DR/SR/RR/SL/wave-length/frequency registers and key commands. Holds each key command pending
//   until the generator's time-multiplexed slot for that channel consumes it. Provides register readback.
// PARAMETERS
//   NUM_CH   5   channel count; channel n = a..e; fixed at 5 for this generator
// PORTS
//   nreset                 in   1     async reset, active low
//   clk                    in   1     system clock (21.477 MHz)
//   bus_wr                 in   1     write strobe, one cycle per access
//   bus_rd                 in   1     read strobe, one cycle per access
//   bus_address            in   6     [5:3] channel 0..4, [2:0] register offset
//   bus_wdata              in   8     write data
//   bus_rdata              out  8     read data, valid 1 cycle after bus_rd
//   active                 in   3     generator slot: 0..4 = channel index, 5..7 = no operation
//   key_on / key_release   out  5     pending command per channel, bit n = channel n
//   key_off                out  5     pending key-off per channel, bit n = channel n
//   reg_ar/dr/sr/rr        out  40    8 bits per channel, channel n in [8n+7:8n]
//   reg_sl                 out  30    6 bits per channel, [6n+5:6n]
//   reg_wave_length        out  10    2 bits per channel, [2n+1:2n]
//   reg_frequency_count    out  60    12 bits per channel, [12n+11:12n]
// BEHAVIOUR
//   Reset (async, nreset=0): all reg_* = 0, all key_* = 0, bus_rdata = 0; pending commands discarded.
//   Register map per channel (offset):
//     0 AR[7:0]; 1 DR[7:0]; 2 SR[7:0]; 3 RR[7:0]; 4 SL = wdata[5:0]
//     5 wave_length = wdata[1:0]; key cmd wdata[4]=on, [5]=release, [6]=off
//     6 freq[7:0]; 7 freq[11:8] = wdata[3:0]
//   Write: on posedge with bus_wr=1 and channel<5, addressed field updates; visible on reg_* next cycle.
//     Writes with channel 5..7 are ignored.
//   Key command (offset 5):
//     - Multiple bits set in one write: off > on > release.
//     - Exactly one key_* bit per channel is ever asserted.
//     - All-zero command bits leave pending state unchanged.
//     - New command replaces any still-pending command for that channel.
//   Consumption:
//     - key_*[n] is a level held from the cycle after the write until consumed.
//     - Consumed at the first posedge where active==n; the generator samples at that same edge, and
//       key_*[n] is 0 the next cycle.
//     - active 5..7 consumes nothing.
//     - Write of a new command to channel n on the consuming edge: new command becomes pending
//       (write wins).
//   Read:
//     - posedge with bus_rd=1: bus_rdata <= field zero-extended.
//     - Offset 5 returns {1'b0, off, release, on, 2'b00, wave_length}.
//     - Channel 5..7 returns 0. bus_rdata holds its value when bus_rd=0.
//     - bus_rd and bus_wr in the same cycle to the same address: read returns the old value.
//   Reset asserted mid-pending: command lost; no key pulse after reset release.
// TESTING
//   1 Reset, then idle 50 clk -> all reg_* 0, key_* 0, bus_rdata 0.
//   2 Write ch0 offsets 0..4 = 2,3,100,4,60; read back each -> 2,3,100,4,60 one cycle after bus_rd;
//     reg_ar[7:0]=2, reg_sl[5:0]=60.
//   3 active held 5; write ch0 off5=0x10 -> key_on[0]=1 held; set active=0 -> key_on[0] clears after
//     that edge; exactly one edge with active==0 && key_on[0].
//   4 Write ch2 off5=0x70 -> only key_off[2]=1; then write 0x20 before active==2 -> key_release[2]=1,
//     key_off[2]=0.
//   5 Write ch1 off5=0x10 on the edge where active==1 consumes a prior release -> key_on[1]=1 after
//     that edge.
//   6 Write ch6 (addr 6'h30) -> no reg_* change, read -> 0; pulse nreset while key_on[3] pending ->
//     key_on[3]=0 and stays 0.

Source files
------------

// File: rtl/wts_adsr_key_controller.sv
// CPU-side register file and key-command holder for the 5-channel ADSR envelope generator.
// Key commands stay pending per channel until the generator slot for that channel consumes them.
module wts_adsr_key_controller #(
  parameter int NUM_CH = 5
) (
  input  logic                  nreset,
  input  logic                  clk,
  input  logic                  bus_wr,
  input  logic                  bus_rd,
  input  logic [5:0]            bus_address,
  input  logic [7:0]            bus_wdata,
  output logic [7:0]            bus_rdata,
  input  logic [2:0]            active,
  output logic [NUM_CH-1:0]     key_on,
  output logic [NUM_CH-1:0]     key_release,
  output logic [NUM_CH-1:0]     key_off,
  output logic [8*NUM_CH-1:0]   reg_ar,
  output logic [8*NUM_CH-1:0]   reg_dr,
  output logic [8*NUM_CH-1:0]   reg_sr,
  output logic [8*NUM_CH-1:0]   reg_rr,
  output logic [6*NUM_CH-1:0]   reg_sl,
  output logic [2*NUM_CH-1:0]   reg_wave_length,
  output logic [12*NUM_CH-1:0]  reg_frequency_count
);

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_ON,
    KEY_RELEASE,
    KEY_OFF
  } key_state_e;

  logic [2:0]          bus_channel;
  logic [2:0]          bus_offset;
  logic                cmd_any;
  logic [8*NUM_CH-1:0] ch_rdata;
  logic [7:0]          rd_mux;

  assign bus_channel = bus_address[5:3];
  assign bus_offset  = bus_address[2:0];
  assign cmd_any     = |bus_wdata[6:4];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic       ch_sel;
      logic       ch_wr;
      logic       key_wr;
      logic [7:0] ar_reg;
      logic [7:0] dr_reg;
      logic [7:0] sr_reg;
      logic [7:0] rr_reg;
      logic [5:0] sl_reg;
      logic [1:0] wl_reg;
      logic [11:0] freq_reg;
      logic [7:0] rd_value;
      key_state_e key_state_reg;
      key_state_e key_state_next;

      assign ch_sel = (bus_channel == 3'(gi));
      assign ch_wr  = bus_wr && ch_sel;
      assign key_wr = ch_wr && (bus_offset == 3'd5);

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          ar_reg   <= '0;
          dr_reg   <= '0;
          sr_reg   <= '0;
          rr_reg   <= '0;
          sl_reg   <= '0;
          wl_reg   <= '0;
          freq_reg <= '0;
        end else if (ch_wr) begin
          case (bus_offset)
            3'd0: ar_reg <= bus_wdata;
            3'd1: dr_reg <= bus_wdata;
            3'd2: sr_reg <= bus_wdata;
            3'd3: rr_reg <= bus_wdata;
            3'd4: sl_reg <= bus_wdata[5:0];
            3'd5: wl_reg <= bus_wdata[1:0];
            3'd6: freq_reg[7:0]  <= bus_wdata;
            default: freq_reg[11:8] <= bus_wdata[3:0];
          endcase
        end
      end

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          key_state_reg <= KEY_IDLE;
        end else begin
          key_state_reg <= key_state_next;
        end
      end

      // A command written on the consuming edge overrides the consumption.
      always_comb begin
        key_state_next = key_state_reg;
        if (active == 3'(gi)) begin
          key_state_next = KEY_IDLE;
        end
        if (key_wr && cmd_any) begin
          if (bus_wdata[6]) begin
            key_state_next = KEY_OFF;
          end else if (bus_wdata[4]) begin
            key_state_next = KEY_ON;
          end else begin
            key_state_next = KEY_RELEASE;
          end
        end
      end

      always_comb begin
        rd_value = '0;
        case (bus_offset)
          3'd0: rd_value = ar_reg;
          3'd1: rd_value = dr_reg;
          3'd2: rd_value = sr_reg;
          3'd3: rd_value = rr_reg;
          3'd4: rd_value = {2'b00, sl_reg};
          3'd5: rd_value = {1'b0, key_off[gi], key_release[gi], key_on[gi], 2'b00, wl_reg};
          3'd6: rd_value = freq_reg[7:0];
          default: rd_value = {4'h0, freq_reg[11:8]};
        endcase
      end

      assign key_on[gi]      = (key_state_reg == KEY_ON);
      assign key_release[gi] = (key_state_reg == KEY_RELEASE);
      assign key_off[gi]     = (key_state_reg == KEY_OFF);

      assign reg_ar[8*gi +: 8]               = ar_reg;
      assign reg_dr[8*gi +: 8]               = dr_reg;
      assign reg_sr[8*gi +: 8]               = sr_reg;
      assign reg_rr[8*gi +: 8]               = rr_reg;
      assign reg_sl[6*gi +: 6]               = sl_reg;
      assign reg_wave_length[2*gi +: 2]      = wl_reg;
      assign reg_frequency_count[12*gi +: 12] = freq_reg;
      assign ch_rdata[8*gi +: 8]             = rd_value;
    end
  endgenerate

  // Channel numbers beyond NUM_CH fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus_channel == 3'(i)) begin
        rd_mux = ch_rdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bus_rdata <= '0;
    end else if (bus_rd) begin
      bus_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_wts_adsr_key_controller.sv
// Directed bench: reads are checked by a scoreboard monitor, key/register levels by direct checks.
module tb_wts_adsr_key_controller;

  logic        nreset;
  logic        clk;
  logic        bus_wr;
  logic        bus_rd;
  logic [5:0]  bus_address;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic [2:0]  active;
  logic [4:0]  key_on;
  logic [4:0]  key_release;
  logic [4:0]  key_off;
  logic [39:0] reg_ar;
  logic [39:0] reg_dr;
  logic [39:0] reg_sr;
  logic [39:0] reg_rr;
  logic [29:0] reg_sl;
  logic [9:0]  reg_wave_length;
  logic [59:0] reg_frequency_count;

  wts_adsr_key_controller dut (
    .nreset(nreset),
    .clk(clk),
    .bus_wr(bus_wr),
    .bus_rd(bus_rd),
    .bus_address(bus_address),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .active(active),
    .key_on(key_on),
    .key_release(key_release),
    .key_off(key_off),
    .reg_ar(reg_ar),
    .reg_dr(reg_dr),
    .reg_sr(reg_sr),
    .reg_rr(reg_rr),
    .reg_sl(reg_sl),
    .reg_wave_length(reg_wave_length),
    .reg_frequency_count(reg_frequency_count)
  );

  typedef struct {
    string      name;
    logic [7:0] exp;
  } rd_item_t;

  rd_item_t rd_q[$];
  int       checks = 0;
  int       errors = 0;
  logic     rd_seen = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: a read issued at a posedge presents bus_rdata for the following half cycle.
  always @(posedge clk) rd_seen <= bus_rd && nreset;

  always @(negedge clk) begin
    if (rd_seen) begin
      rd_item_t it;
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %02h, no expected read queued", bus_rdata);
      end else begin
        it = rd_q.pop_front();
        if (bus_rdata !== it.exp) begin
          errors++;
          $display("FAIL %s: got %02h, expected %02h", it.name, bus_rdata, it.exp);
        end else begin
          $display("read  %-14s rdata=%02h ok", it.name, bus_rdata);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("check %-14s value=%0h ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [7:0] data);
    bus_wr      = 1'b1;
    bus_address = addr;
    bus_wdata   = data;
    tick();
    bus_wr = 1'b0;
    $display("write addr=%02h data=%02h", addr, data);
  endtask

  task automatic rd(input logic [5:0] addr, input logic [7:0] exp, input string name);
    rd_item_t it;
    it.name = name;
    it.exp  = exp;
    rd_q.push_back(it);
    bus_rd      = 1'b1;
    bus_address = addr;
    tick();
    bus_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    nreset = 1'b0;
    bus_wr = 1'b0;
    bus_rd = 1'b0;
    bus_address = '0;
    bus_wdata = '0;
    active = 3'd5;
    repeat (3) tick();
    nreset = 1'b1;

    // 1: reset state after idle
    repeat (50) tick();
    chk("rst_ar", {24'h0, reg_ar}, 64'h0);
    chk("rst_sl_wl", {24'h0, reg_sl, reg_wave_length}, 64'h0);
    chk("rst_freq", {4'h0, reg_frequency_count}, 64'h0);
    chk("rst_keys", {49'h0, key_on, key_release, key_off}, 64'h0);
    chk("rst_rdata", {56'h0, bus_rdata}, 64'h0);

    // 2: envelope registers on channel 0
    wr(6'h00, 8'd2);
    wr(6'h01, 8'd3);
    wr(6'h02, 8'd100);
    wr(6'h03, 8'd4);
    wr(6'h04, 8'd60);
    wr(6'h06, 8'h23);
    wr(6'h07, 8'hF1);
    rd(6'h00, 8'd2, "rd_ar0");
    rd(6'h01, 8'd3, "rd_dr0");
    rd(6'h02, 8'd100, "rd_sr0");
    rd(6'h03, 8'd4, "rd_rr0");
    rd(6'h04, 8'd60, "rd_sl0");
    rd(6'h06, 8'h23, "rd_freq_lo0");
    rd(6'h07, 8'h01, "rd_freq_hi0");
    chk("reg_ar0", {56'h0, reg_ar[7:0]}, 64'd2);
    chk("reg_sl0", {58'h0, reg_sl[5:0]}, 64'd60);
    chk("reg_freq0", {52'h0, reg_frequency_count[11:0]}, 64'h123);

    // 3: key on held until slot 0 consumes it
    wr(6'h05, 8'h12);
    chk("key_on0_set", {63'h0, key_on[0]}, 64'd1);
    chk("wl0", {62'h0, reg_wave_length[1:0]}, 64'd2);
    rd(6'h05, 8'h12, "rd_cmd0_pend");
    repeat (3) tick();
    chk("key_on0_held", {63'h0, key_on[0]}, 64'd1);
    active = 3'd0;
    edges = 0;
    for (int i = 0; i < 4; i++) begin
      if (active == 3'd0 && key_on[0]) edges++;
      tick();
    end
    active = 3'd5;
    chk("consume_edges0", 64'(edges), 64'd1);
    chk("key_on0_clr", {63'h0, key_on[0]}, 64'd0);
    rd(6'h05, 8'h02, "rd_cmd0_done");

    // 4: priority and replacement on channel 2
    wr(6'h15, 8'h70);
    chk("keys_off2", {49'h0, key_on, key_release, key_off}, 64'h004);
    wr(6'h15, 8'h20);
    chk("keys_rel2", {49'h0, key_on, key_release, key_off}, 64'h080);
    rd(6'h15, 8'h20, "rd_cmd2");
    active = 3'd2;
    tick();
    active = 3'd5;
    chk("key_rel2_clr", {63'h0, key_release[2]}, 64'd0);

    // 5: write wins over consumption on channel 1
    wr(6'h0D, 8'h20);
    chk("key_rel1_set", {63'h0, key_release[1]}, 64'd1);
    active = 3'd1;
    wr(6'h0D, 8'h10);
    active = 3'd5;
    chk("key_on1_win", {62'h0, key_on[1], key_release[1]}, 64'h2);
    wr(6'h0D, 8'h01);
    chk("key_on1_keep", {63'h0, key_on[1]}, 64'd1);
    rd(6'h0D, 8'h11, "rd_cmd1");
    active = 3'd1;
    tick();
    active = 3'd5;
    chk("key_on1_clr", {63'h0, key_on[1]}, 64'd0);

    // 6: out-of-range channel, read hold, read-before-write, reset mid-pending
    wr(6'h30, 8'hAA);
    chk("ch6_ar", {24'h0, reg_ar}, 64'h2);
    chk("ch6_sr", {24'h0, reg_sr}, 64'd100);
    rd(6'h30, 8'h00, "rd_ch6");
    rd(6'h00, 8'd2, "rd_ar0_again");
    repeat (2) tick();
    chk("rdata_hold", {56'h0, bus_rdata}, 64'd2);
    begin
      rd_item_t it;
      it.name = "rd_wr_same";
      it.exp  = 8'd3;
      rd_q.push_back(it);
      bus_rd = 1'b1;
      bus_wr = 1'b1;
      bus_address = 6'h01;
      bus_wdata = 8'h55;
      tick();
      bus_rd = 1'b0;
      bus_wr = 1'b0;
    end
    chk("dr0_new", {56'h0, reg_dr[7:0]}, 64'h55);
    wr(6'h1D, 8'h10);
    chk("key_on3_set", {63'h0, key_on[3]}, 64'd1);
    #2;
    nreset = 1'b0;
    #1;
    chk("key_on3_async", {63'h0, key_on[3]}, 64'd0);
    tick();
    nreset = 1'b1;
    active = 3'd3;
    repeat (5) tick();
    active = 3'd5;
    chk("key_on3_stay", {59'h0, key_on}, 64'd0);
    chk("post_rst_ar", {24'h0, reg_ar}, 64'h0);
    chk("post_rst_rdata", {56'h0, bus_rdata}, 64'h0);

    tick();
    chk("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
